// File: rtl/pool_1d_pkg.sv
// Shared definitions for the 1-D pooling / unpooling datapath pair.
// Holds default data width and window length, the index width derivation,
// and the two-state window sequencer encoding used by both directions.
package pool_1d_pkg;

    localparam int POOL_DATA_W = 32;
    localparam int POOL_KERNEL = 4;

    // Width of an in-window index. A window of 2 still needs one bit, and
    // $clog2 alone would give the right answer there, but clamp at 1 so a
    // degenerate caller never ends up with a zero-width vector.
    function automatic int idx_w(input int kernel);
        if (kernel <= 2) begin
            return 1;
        end
        return $clog2(kernel);
    endfunction

    // IDLE: waiting for a pooled word. EMIT: streaming the window's beats.
    typedef enum logic [0:0] {
        IDLE = 1'b0,
        EMIT = 1'b1
    } pool_state_e;

endpackage : pool_1d_pkg

// File: rtl/max_unpool_1d.sv
// Streaming 1-D max-unpooling: one pooled value + argmax index in, KERNEL beats out,
// value on the argmax beat and zero elsewhere. First beat one cycle after accept.
// Output holds under ready_out=0; ready_in rises only on the final beat's transfer.
//
// Ports:
//   clk, rst                  - clock, asynchronous active-high reset
//   valid_in/ready_in         - input handshake; input_data, input_idx, last_in
//   valid_out/ready_out       - output handshake; output_data, last_out
//   idx_err, err_cnt          - only with MAX_UNPOOL_IDX_CHECK_EN defined: sticky
//                               out-of-range index flag and 16-bit saturating count
module max_unpool_1d
    import pool_1d_pkg::*;
#(
    parameter int DATA_W = POOL_DATA_W,
    parameter int KERNEL = POOL_KERNEL,
    parameter int IDX_W  = idx_w(KERNEL)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              valid_in,
    output logic              ready_in,
    input  logic [DATA_W-1:0] input_data,
    input  logic [IDX_W-1:0]  input_idx,
    input  logic              last_in,
    output logic              valid_out,
    input  logic              ready_out,
    output logic [DATA_W-1:0] output_data,
    output logic              last_out
`ifdef MAX_UNPOOL_IDX_CHECK_EN
    ,
    output logic              idx_err,
    output logic [15:0]       err_cnt
`endif
);

    localparam logic [IDX_W-1:0] LAST_POS = IDX_W'(KERNEL - 1);

    pool_state_e       state_q, state_d;
    logic [IDX_W-1:0]  pos_q,   pos_d;
    logic [DATA_W-1:0] val_q,   val_d;
    logic [IDX_W-1:0]  idx_q,   idx_d;
    logic              last_q,  last_d;

    logic at_end;
    logic in_xfer;

    assign at_end  = (pos_q == LAST_POS);
    assign in_xfer = valid_in && ready_in;

    // ------------------------------------------------------------------
    // Window sequencer
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            pos_q   <= '0;
            val_q   <= '0;
            idx_q   <= '0;
            last_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pos_q   <= pos_d;
            val_q   <= val_d;
            idx_q   <= idx_d;
            last_q  <= last_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        pos_d     = pos_q;
        val_d     = val_q;
        idx_d     = idx_q;
        last_d    = last_q;
        ready_in  = 1'b0;
        valid_out = 1'b0;

        case (state_q)
            IDLE: begin
                ready_in = 1'b1;
                if (valid_in) begin
                    val_d   = input_data;
                    idx_d   = input_idx;
                    last_d  = last_in;
                    pos_d   = '0;
                    state_d = EMIT;
                end
            end

            EMIT: begin
                valid_out = 1'b1;
                // Accept the next window on the cycle the final beat leaves,
                // so back-to-back windows stream with no idle bubble.
                ready_in  = at_end && ready_out;
                if (ready_out) begin
                    if (!at_end) begin
                        pos_d = pos_q + 1'b1;
                    end else if (valid_in) begin
                        val_d   = input_data;
                        idx_d   = input_idx;
                        last_d  = last_in;
                        pos_d   = '0;
                        state_d = EMIT;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Outputs decode purely from registered state, so they are stable for as
    // long as ready_out holds the beat. An index >= KERNEL never matches pos,
    // which yields an all-zero window without any extra logic.
    assign output_data = (state_q == EMIT && pos_q == idx_q) ? val_q : '0;
    assign last_out    = (state_q == EMIT) && last_q && at_end;

`ifdef MAX_UNPOOL_IDX_CHECK_EN
    // ------------------------------------------------------------------
    // Out-of-range index monitor (observational only; data path unchanged)
    // ------------------------------------------------------------------
    localparam logic [IDX_W:0] KERNEL_EXT = (IDX_W + 1)'(KERNEL);

    logic        bad_idx;
    logic        idx_err_q, idx_err_d;
    logic [15:0] err_cnt_q, err_cnt_d;

    assign bad_idx = in_xfer && ({1'b0, input_idx} >= KERNEL_EXT);

    always_comb begin
        idx_err_d = idx_err_q;
        err_cnt_d = err_cnt_q;
        if (bad_idx) begin
            idx_err_d = 1'b1;
            if (err_cnt_q != 16'hFFFF) begin
                err_cnt_d = err_cnt_q + 16'd1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx_err_q <= 1'b0;
            err_cnt_q <= '0;
        end else begin
            idx_err_q <= idx_err_d;
            err_cnt_q <= err_cnt_d;
        end
    end

    assign idx_err = idx_err_q;
    assign err_cnt = err_cnt_q;
`else
    // in_xfer only feeds the index monitor; keep it referenced when absent.
    logic unused_in_xfer;
    assign unused_in_xfer = in_xfer;
`endif

endmodule : max_unpool_1d

// File: tb/tb_max_unpool_1d.sv
// Directed bench for max_unpool_1d: a KERNEL=4 instance for the main streaming
// scenarios and a KERNEL=3 instance for the non-power-of-2 index range cases.
module tb_max_unpool_1d;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;

    // KERNEL = 4 instance
    logic        vi4 = 1'b0, ro4 = 1'b0, li4 = 1'b0;
    logic [31:0] din4 = '0;
    logic [1:0]  idx4 = '0;
    logic        rdy4, vo4, lo4;
    logic [31:0] dout4;
`ifdef MAX_UNPOOL_IDX_CHECK_EN
    logic        ierr4;
    logic [15:0] ecnt4;
`endif

    // KERNEL = 3 instance
    logic        vi3 = 1'b0, ro3 = 1'b0, li3 = 1'b0;
    logic [31:0] din3 = '0;
    logic [1:0]  idx3 = '0;
    logic        rdy3, vo3, lo3;
    logic [31:0] dout3;
`ifdef MAX_UNPOOL_IDX_CHECK_EN
    logic        ierr3;
    logic [15:0] ecnt3;
`endif

    max_unpool_1d #(.DATA_W(32), .KERNEL(4)) dut4 (
        .clk(clk), .rst(rst),
        .valid_in(vi4), .ready_in(rdy4), .input_data(din4), .input_idx(idx4), .last_in(li4),
        .valid_out(vo4), .ready_out(ro4), .output_data(dout4), .last_out(lo4)
`ifdef MAX_UNPOOL_IDX_CHECK_EN
        , .idx_err(ierr4), .err_cnt(ecnt4)
`endif
    );

    max_unpool_1d #(.DATA_W(32), .KERNEL(3)) dut3 (
        .clk(clk), .rst(rst),
        .valid_in(vi3), .ready_in(rdy3), .input_data(din3), .input_idx(idx3), .last_in(li3),
        .valid_out(vo3), .ready_out(ro3), .output_data(dout3), .last_out(lo3)
`ifdef MAX_UNPOOL_IDX_CHECK_EN
        , .idx_err(ierr3), .err_cnt(ecnt3)
`endif
    );

    task automatic test_reset();
        rst = 1'b1;
        #2;
        vectors++;
        if (vo4 !== 1'b0 || dout4 !== 32'h0 || lo4 !== 1'b0 || rdy4 !== 1'b1) begin
            miscompares++;
            $display("FAIL reset_k4: valid_out=%b data=%h last=%b ready_in=%b, want 0 0 0 1",
                     vo4, dout4, lo4, rdy4);
        end
        vectors++;
        if (vo3 !== 1'b0 || rdy3 !== 1'b1) begin
            miscompares++;
            $display("FAIL reset_k3: valid_out=%b ready_in=%b, want 0 1", vo3, rdy3);
        end
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_idle();
        ro4 = 1'b1;
        vi4 = 1'b0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            #1;
            vectors++;
            if (vo4 !== 1'b0 || rdy4 !== 1'b1) begin
                miscompares++;
                $display("FAIL idle c%0d: valid_out=%b ready_in=%b, want 0 1", c, vo4, rdy4);
            end
        end
    endtask

    task automatic test_single_window();
        @(negedge clk);
        vi4 = 1'b1; din4 = 32'h0000_00AB; idx4 = 2'd2; li4 = 1'b1; ro4 = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            vi4 = 1'b0;
            #1;
            vectors++;
            if (vo4 !== 1'b1 || dout4 !== ((k == 2) ? 32'hAB : 32'h0) ||
                lo4 !== (k == 3) || rdy4 !== (k == 3)) begin
                miscompares++;
                $display("FAIL single beat%0d: valid=%b data=%h last=%b ready_in=%b, want 1 %h %b %b",
                         k, vo4, dout4, lo4, rdy4, (k == 2) ? 32'hAB : 32'h0, k == 3, k == 3);
            end
        end
        @(negedge clk);
        #1;
        vectors++;
        if (vo4 !== 1'b0 || rdy4 !== 1'b1) begin
            miscompares++;
            $display("FAIL single_after: valid_out=%b ready_in=%b, want 0 1", vo4, rdy4);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] exp [0:7];
        exp = '{32'h11, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h22};
        @(negedge clk);
        vi4 = 1'b1; din4 = 32'h11; idx4 = 2'd0; li4 = 1'b0; ro4 = 1'b1;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (k == 0) begin
                din4 = 32'h22; idx4 = 2'd3; li4 = 1'b1;
            end
            if (k == 4) vi4 = 1'b0;
            #1;
            vectors++;
            if (vo4 !== 1'b1 || dout4 !== exp[k] || lo4 !== (k == 7) ||
                rdy4 !== (k == 3 || k == 7)) begin
                miscompares++;
                $display("FAIL b2b beat%0d: valid=%b data=%h last=%b ready_in=%b, want 1 %h %b %b",
                         k, vo4, dout4, lo4, rdy4, exp[k], k == 7, k == 3 || k == 7);
            end
        end
        @(negedge clk);
        #1;
        vectors++;
        if (vo4 !== 1'b0) begin
            miscompares++;
            $display("FAIL b2b_after: valid_out=%b, want 0", vo4);
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] exp [0:6];
        logic        rpat [0:6];
        int          xfers = 0;
        exp  = '{32'h0, 32'h55, 32'h55, 32'h55, 32'h55, 32'h0, 32'h0};
        rpat = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
        @(negedge clk);
        vi4 = 1'b1; din4 = 32'h55; idx4 = 2'd1; li4 = 1'b0; ro4 = 1'b1;
        for (int c = 0; c < 7; c++) begin
            @(negedge clk);
            vi4 = 1'b0;
            ro4 = rpat[c];
            #1;
            vectors++;
            if (vo4 !== 1'b1 || dout4 !== exp[c] || lo4 !== 1'b0) begin
                miscompares++;
                $display("FAIL bp c%0d: valid=%b data=%h last=%b, want 1 %h 0",
                         c, vo4, dout4, lo4, exp[c]);
            end
            if (vo4 && ro4) xfers++;
        end
        vectors++;
        if (xfers !== 4) begin
            miscompares++;
            $display("FAIL bp_count: transfers=%0d, want 4", xfers);
        end
        ro4 = 1'b1;
        @(negedge clk);
        #1;
        vectors++;
        if (vo4 !== 1'b0) begin
            miscompares++;
            $display("FAIL bp_after: valid_out=%b, want 0 (extra beat)", vo4);
        end
    endtask

    task automatic test_reset_mid_window();
        @(negedge clk);
        vi4 = 1'b1; din4 = 32'h77; idx4 = 2'd3; li4 = 1'b1; ro4 = 1'b1;
        @(negedge clk);
        vi4 = 1'b0;
        #1;
        vectors++;
        if (vo4 !== 1'b1 || dout4 !== 32'h0) begin
            miscompares++;
            $display("FAIL rmw_beat1: valid=%b data=%h, want 1 0", vo4, dout4);
        end
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        vectors++;
        if (vo4 !== 1'b0 || dout4 !== 32'h0 || lo4 !== 1'b0) begin
            miscompares++;
            $display("FAIL rmw_async: valid=%b data=%h last=%b, want 0 0 0", vo4, dout4, lo4);
        end
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        vectors++;
        if (rdy4 !== 1'b1) begin
            miscompares++;
            $display("FAIL rmw_ready: ready_in=%b, want 1", rdy4);
        end
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            #1;
            vectors++;
            if (vo4 !== 1'b0 || dout4 !== 32'h0) begin
                miscompares++;
                $display("FAIL rmw_stale c%0d: valid=%b data=%h, want 0 0", c, vo4, dout4);
            end
        end
    endtask

    task automatic test_idx_range();
        ro3 = 1'b1;
        // In-range window on the non-power-of-2 instance: value on the last beat.
        @(negedge clk);
        vi3 = 1'b1; din3 = 32'h33; idx3 = 2'd2; li3 = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            vi3 = 1'b0;
            #1;
            vectors++;
            if (vo3 !== 1'b1 || dout3 !== ((k == 2) ? 32'h33 : 32'h0) || lo3 !== (k == 2)) begin
                miscompares++;
                $display("FAIL k3_good beat%0d: valid=%b data=%h last=%b, want 1 %h %b",
                         k, vo3, dout3, lo3, (k == 2) ? 32'h33 : 32'h0, k == 2);
            end
        end
`ifdef MAX_UNPOOL_IDX_CHECK_EN
        vectors++;
        if (ierr3 !== 1'b0 || ecnt3 !== 16'd0) begin
            miscompares++;
            $display("FAIL k3_good_err: idx_err=%b err_cnt=%0d, want 0 0", ierr3, ecnt3);
        end
`endif
        // Three out-of-range windows: each must emit only zeros.
        for (int n = 0; n < 3; n++) begin
            @(negedge clk);
            vi3 = 1'b1; din3 = 32'h99 + n; idx3 = 2'd3; li3 = 1'b1;
            for (int k = 0; k < 3; k++) begin
                @(negedge clk);
                vi3 = 1'b0;
                #1;
                vectors++;
                if (vo3 !== 1'b1 || dout3 !== 32'h0 || lo3 !== (k == 2) || rdy3 !== (k == 2)) begin
                    miscompares++;
                    $display("FAIL k3_bad w%0d beat%0d: valid=%b data=%h last=%b ready_in=%b, want 1 0 %b %b",
                             n, k, vo3, dout3, lo3, rdy3, k == 2, k == 2);
                end
            end
`ifdef MAX_UNPOOL_IDX_CHECK_EN
            if (n == 0) begin
                vectors++;
                if (ierr3 !== 1'b1 || ecnt3 !== 16'd1) begin
                    miscompares++;
                    $display("FAIL k3_err1: idx_err=%b err_cnt=%0d, want 1 1", ierr3, ecnt3);
                end
            end
`endif
        end
`ifdef MAX_UNPOOL_IDX_CHECK_EN
        vectors++;
        if (ierr3 !== 1'b1 || ecnt3 !== 16'd3) begin
            miscompares++;
            $display("FAIL k3_err3: idx_err=%b err_cnt=%0d, want 1 3", ierr3, ecnt3);
        end
`endif
        @(negedge clk);
        #1;
        vectors++;
        if (vo3 !== 1'b0) begin
            miscompares++;
            $display("FAIL k3_after: valid_out=%b, want 0", vo3);
        end
    endtask

    initial begin
        test_reset();
        test_idle();
        test_single_window();
        test_back_to_back();
        test_backpressure();
        test_reset_mid_window();
        test_idx_range();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule : tb_max_unpool_1d

// File: doc/max_unpool_1d.md
Name: max_unpool_1d

Overview:
Streaming 1-D max-unpooling block, the inverse of the max-pooling stage. It consumes one pooled value plus its in-window argmax index per handshake and expands it to KERNEL output beats. The beat at the argmax position carries the value; all other beats are zero. It sits downstream of the pooling datapath, in decoder and upsampling paths, with stride equal to KERNEL (non-overlapping windows).

Parameters:
DATA_W, 32, width of the data word.
KERNEL, 4, window length and stride, 2..256.
IDX_W, $clog2(KERNEL), width of the in-window argmax index.

Ports:
clk  in  1  clock, all logic on the rising edge
rst  in  1  asynchronous, active-high reset
valid_in  in  1  input word and index valid
ready_in  out  1  block can accept an input this cycle
input_data  in  DATA_W  pooled value
input_idx  in  IDX_W  argmax position within the window, 0..KERNEL-1
last_in  in  1  this pooled value is the last of its row
valid_out  out  1  output beat valid
ready_out  in  1  downstream accepts the beat
output_data  out  DATA_W  unpooled beat
last_out  out  1  final beat of a row

Behaviour:
- Reset (async assert, sync release): state=IDLE, pos=0, held value/idx/last=0. Outputs: valid_out=0, output_data=0, last_out=0, ready_in=1.
- Handshakes:
  - Input transfer when valid_in&&ready_in.
  - Output transfer when valid_out&&ready_out.
  - Output holds output_data and last_out stable while valid_out=1 and ready_out=0.
  - valid_out never drops without a transfer.
- States:
  - IDLE: ready_in=1, valid_out=0. On input transfer, capture data/idx/last, set pos=0, go to EMIT.
  - EMIT: valid_out=1.
    - output_data = (pos==idx_r) ? val_r : 0.
    - last_out = last_r && (pos==KERNEL-1).
    - On output transfer with pos<KERNEL-1: pos++.
    - On output transfer with pos==KERNEL-1: window done.
- Window done:
  - ready_in = (state==IDLE) || (pos==KERNEL-1 && ready_out).
  - If an input transfers in the same cycle, recapture, set pos=0, stay in EMIT (back-to-back, no bubble).
  - Otherwise go to IDLE.
- Latency: first beat of a window is valid the cycle after its input transfer. Sustained throughput is 1 input per KERNEL cycles with ready_out held high.
- Out-of-range index: input_idx>=KERNEL (non-power-of-2 KERNEL) emits all-zero beats for that window. This is not an error stall.
- Zero value at argmax: emitted as 0; indistinguishable from fill by design.
- Reset mid-window: the partial window is discarded and no further beats are emitted.
- pos width: IDX_W bits; it never wraps past KERNEL-1.

Optional Feature:
Macro MAX_UNPOOL_IDX_CHECK_EN.
- Defined: adds output port idx_err (1 bit) and a 16-bit saturating register err_cnt (output port).
  - idx_err is set sticky on any accepted input with input_idx>=KERNEL.
  - err_cnt increments on each such input and saturates at 0xFFFF.
  - Both clear only on rst.
- Not defined: ports absent, no check logic. Data behaviour is identical.

Decomposition:
- Shared package pool_1d_pkg:
  - DATA_W and KERNEL defaults.
  - IDX_W derivation function.
  - state enum {IDLE, EMIT}, reused by the max_pooling_1d counterpart.
- No sub-module is warranted. Counter and mux are inline, as one module of about 150 lines.

Test Plan:
- Single window, KERNEL=4, data=0x0000_00AB, idx=2, last=1, ready_out=1 -> beats 0,0,0xAB,0 on cycles T+1..T+4; last_out only on the 4th beat; ready_in=0 during beats 1-3.
- Back-to-back: inputs (0x11,idx0),(0x22,idx3) with valid_in held -> 8 contiguous beats 0x11,0,0,0,0,0,0,0x22; second input accepted on the cycle of beat 4.
- Backpressure: ready_out low for 3 cycles during beat 2 of (0x55,idx1) -> output_data=0x55 held stable; total 4 transfers, no duplicate or lost beat.
- Reset mid-window: assert rst after beat 1 of (0x77,idx3) -> valid_out=0 immediately (async); after release ready_in=1 and no stale 0x77 appears.
- Idx range, KERNEL=3, idx=3 -> three zero beats.
  - With MAX_UNPOOL_IDX_CHECK_EN defined: idx_err=1 and err_cnt=1.
  - After 2 more bad inputs, err_cnt=3.
- Idle behaviour: valid_in=0 for 10 cycles after reset -> valid_out=0 and ready_in=1 throughout.
